platform_renderer: RTL and testbench
====================================

// Module: platform_renderer
// PURPOSE
//  Parametrised successor to the fixed-table pixel colour mapper. Holds NUM_PLAT runtime-writable
//  platforms in a double-buffered register table, applies a per-frame vertical scroll with
//  wrap-around, and produces registered RGB for each (DrawX, DrawY) through a 2-stage pipeline.
//  Sits between the game-logic FSM (platform writes, scroll) and the VGA controller (pixel stream).
// PARAMETERS
//  NUM_PLAT     16      number of platform slots (1..64)
//  COORD_W      10      coordinate width, all X/Y/size ports
//  SCREEN_H     480     vertical wrap modulus for scrolled Y
//  PLAT_HW      16      platform half-width in pixels
//  PLAT_HH      4       platform half-height in pixels
//  BG_RGB       24'h696969  background colour {R,G,B}
//  PLAT_RGB     24'h66BB11  platform colour
//  BALL_RGB     24'hCAC92E  ball colour
//  CANNON_RGB   24'hFF0000  cannon colour
// PORTS
//  Clk          in   1        pixel/system clock, single clock domain
//  Reset_n      in   1        asynchronous, active-low reset
//  wr_en        in   1        write one shadow-table slot this cycle
//  wr_idx       in   $clog2(NUM_PLAT)  slot index; writes to idx >= NUM_PLAT ignored
//  wr_x, wr_y   in   COORD_W  platform centre (unscrolled Y)
//  wr_valid     in   1        slot enable written with the slot
//  frame_start  in   1        one-cycle pulse at start of vertical blank
//  scroll_dy    in   COORD_W  rows to scroll down, sampled on frame_start; must be < SCREEN_H
//  DrawX, DrawY in   COORD_W  current pixel
//  BallX, BallY, Ball_size       in COORD_W  ball centre / half-size
//  CannonX, CannonY, CannonS     in COORD_W  cannon centre / half-size
//  Red, Green, Blue out  8    registered pixel colour
//  hit_frame    out  1        ball overlapped a platform during previous frame (macro only)
// BEHAVIOUR
//  - Reset: all shadow/active valid bits 0, X/Y 0, scroll_off 0, pipeline regs 0,
//    Red/Green/Blue = 0, hit_frame = 0. Reset mid-frame aborts pipeline; first valid RGB 2 cycles after release.
//  - Writes: wr_en updates shadow[wr_idx] {valid,x,y} at clock edge; never affects active table directly.
//  - Commit: on frame_start, active <= shadow (all slots); a write in the same cycle IS included
//    (shadow next-value forwarded). scroll_off <= (scroll_off + scroll_dy) mod SCREEN_H, computed in
//    COORD_W+1 bits with a single conditional subtract.
//  - Scrolled Y per slot: sy = y + scroll_off, minus SCREEN_H if >= SCREEN_H (COORD_W+1 bit compare).
//  - Box tests inclusive: |DrawX-cx| <= half and |DrawY-cy| <= half, evaluated with signed
//    COORD_W+1 differences, so centres near 0 do not underflow (no unsigned wrap as in old mapper).
//  - Platform box uses PLAT_HW x PLAT_HH; invalid slots never match. Wrapped platforms straddling
//    row 0/SCREEN_H-1 draw only the in-range part (no split rendering).
//  - Pipeline, latency 2: stage 1 registers plat_hit (OR over slots), ball_on, cannon_on;
//    stage 2 registers colour by priority ball > platform > cannon > background.
//    DrawX/DrawY at cycle t -> RGB at cycle t+2, one pixel per cycle, no stalls.
//  - frame_start has no effect on pixels already in the pipeline.
// CONFIGURATION
//  PLAT_COLLIDE_EN defined: stage-1 sticky flag sets when ball_on && plat_hit on same pixel;
//    on frame_start hit_frame <= sticky (including same-cycle set), sticky clears. hit_frame holds
//    for one frame.
//  PLAT_COLLIDE_EN undefined: no collision logic; hit_frame tied 0.
// TESTING
//  1 Reset then DrawX/Y sweep, no writes -> every pixel BG_RGB 69/69/69 at t+2; hit_frame 0.
//  2 Write slot 3 {1,100,200}, no frame_start -> pixel (100,200) still background;
//    after frame_start -> (100,200),(84,196),(116,204) = 66/BB/11; (117,200) background.
//  3 Platform (100,200), ball at (100,200) size 4, cannon same spot -> ball colour CA/C9/2E wins;
//    ball moved away -> platform colour; platform invalidated + commit -> cannon FF/00/00.
//  4 Scroll: slot at y=470, scroll_dy=20 on frame_start -> drawn at y=10; second frame_start with
//    scroll_dy=470 -> scroll_off=10, drawn at y=0 (wrap from 480).
//  5 Same-cycle wr_en(idx 5,{1,300,300}) and frame_start -> platform visible next frame; wr_idx
//    >= NUM_PLAT ignored; Reset_n low mid-line -> RGB 0 immediately, tables cleared.
//  6 PLAT_COLLIDE_EN: ball overlaps platform mid-frame -> hit_frame=1 after next frame_start,
//    0 after following frame_start with no overlap; macro undefined -> hit_frame always 0.

Source files
------------

// File: rtl/platform_renderer.sv
// platform_renderer
//   Pixel colour generator for the platform game. Holds NUM_PLAT runtime-writable
//   platform slots in a double-buffered table (shadow written by game logic, active
//   committed on frame_start), applies a wrapping vertical scroll, and produces
//   registered RGB for each (DrawX, DrawY) with a fixed 2-cycle latency.
//
//   Ports
//     Clk, Reset_n                     clock, async active-low reset
//     wr_en/wr_idx/wr_x/wr_y/wr_valid  shadow-table slot write
//     frame_start, scroll_dy           table commit + scroll accumulate
//     DrawX, DrawY                     current pixel
//     BallX/BallY/Ball_size            ball centre / half-size
//     CannonX/CannonY/CannonS          cannon centre / half-size
//     Red, Green, Blue                 registered pixel colour (t+2)
//     hit_frame                        ball/platform overlap seen in previous frame
//
//   Optional feature macro: PLAT_COLLIDE_EN (collision flag). Without it hit_frame is 0.

// One platform slot: shadow/active registers, scrolled Y and box test.
module plat_slot #(
    parameter int COORD_W  = 10,
    parameter int SCREEN_H = 480,
    parameter int PLAT_HW  = 16,
    parameter int PLAT_HH  = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               i_we,
    input  logic               i_valid,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_commit,
    input  logic [COORD_W-1:0] i_scroll,
    input  logic [COORD_W-1:0] i_px,
    input  logic [COORD_W-1:0] i_py,
    output logic               o_hit
);
    localparam int CW1 = COORD_W + 1;

    // Signed COORD_W+1 difference keeps centres near 0 from wrapping.
    function automatic logic in_box(input logic [COORD_W-1:0] p, c, h);
        logic signed [COORD_W:0] d, hs;
        d  = $signed({1'b0, p}) - $signed({1'b0, c});
        hs = $signed({1'b0, h});
        return (d <= hs) && (d >= -hs);
    endfunction

    logic               r_sh_v, r_ac_v, w_nx_v;
    logic [COORD_W-1:0] r_sh_x, r_sh_y, r_ac_x, r_ac_y, w_nx_x, w_nx_y, w_sy;
    logic [CW1-1:0]     w_sum, w_wrap;

    // Shadow next-value so a write in the commit cycle lands in the active table.
    assign w_nx_v = i_we ? i_valid : r_sh_v;
    assign w_nx_x = i_we ? i_x     : r_sh_x;
    assign w_nx_y = i_we ? i_y     : r_sh_y;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sh_v <= 1'b0; r_sh_x <= '0; r_sh_y <= '0;
            r_ac_v <= 1'b0; r_ac_x <= '0; r_ac_y <= '0;
        end else begin
            r_sh_v <= w_nx_v; r_sh_x <= w_nx_x; r_sh_y <= w_nx_y;
            if (i_commit) begin
                r_ac_v <= w_nx_v; r_ac_x <= w_nx_x; r_ac_y <= w_nx_y;
            end
        end
    end

    assign w_sum  = {1'b0, r_ac_y} + {1'b0, i_scroll};
    assign w_wrap = w_sum - CW1'(SCREEN_H);
    assign w_sy   = (w_sum >= CW1'(SCREEN_H)) ? w_wrap[COORD_W-1:0] : w_sum[COORD_W-1:0];

    assign o_hit = r_ac_v && in_box(i_px, r_ac_x, COORD_W'(PLAT_HW))
                          && in_box(i_py, w_sy,   COORD_W'(PLAT_HH));
endmodule

module platform_renderer #(
    parameter int          NUM_PLAT   = 16,
    parameter int          COORD_W    = 10,
    parameter int          SCREEN_H   = 480,
    parameter int          PLAT_HW    = 16,
    parameter int          PLAT_HH    = 4,
    parameter logic [23:0] BG_RGB     = 24'h696969,
    parameter logic [23:0] PLAT_RGB   = 24'h66BB11,
    parameter logic [23:0] BALL_RGB   = 24'hCAC92E,
    parameter logic [23:0] CANNON_RGB = 24'hFF0000,
    localparam int         IDX_W      = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic               wr_valid,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] scroll_dy,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic [COORD_W-1:0] BallX,
    input  logic [COORD_W-1:0] BallY,
    input  logic [COORD_W-1:0] Ball_size,
    input  logic [COORD_W-1:0] CannonX,
    input  logic [COORD_W-1:0] CannonY,
    input  logic [COORD_W-1:0] CannonS,
    output logic [7:0]         Red,
    output logic [7:0]         Green,
    output logic [7:0]         Blue,
    output logic               hit_frame
);
    localparam int CW1 = COORD_W + 1;

    function automatic logic in_box(input logic [COORD_W-1:0] p, c, h);
        logic signed [COORD_W:0] d, hs;
        d  = $signed({1'b0, p}) - $signed({1'b0, c});
        hs = $signed({1'b0, h});
        return (d <= hs) && (d >= -hs);
    endfunction

    logic [NUM_PLAT-1:0] w_hit;
    logic [COORD_W-1:0]  r_scroll;
    logic [CW1-1:0]      w_ssum, w_swrap;
    logic                w_plat_any, w_ball_on, w_cannon_on;
    logic                r_s1_vld, r_plat_hit, r_ball_on, r_cannon_on;
    logic [23:0]         r_rgb;

    // Slot indices beyond NUM_PLAT-1 match no instance, so such writes are dropped.
    for (genvar i = 0; i < NUM_PLAT; i++) begin : g_slot
        plat_slot #(
            .COORD_W(COORD_W), .SCREEN_H(SCREEN_H), .PLAT_HW(PLAT_HW), .PLAT_HH(PLAT_HH)
        ) u_slot (
            .Clk(Clk), .Reset_n(Reset_n),
            .i_we(wr_en && (wr_idx == IDX_W'(i))),
            .i_valid(wr_valid), .i_x(wr_x), .i_y(wr_y),
            .i_commit(frame_start), .i_scroll(r_scroll),
            .i_px(DrawX), .i_py(DrawY),
            .o_hit(w_hit[i])
        );
    end

    assign w_ssum  = {1'b0, r_scroll} + {1'b0, scroll_dy};
    assign w_swrap = w_ssum - CW1'(SCREEN_H);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)         r_scroll <= '0;
        else if (frame_start) r_scroll <= (w_ssum >= CW1'(SCREEN_H)) ? w_swrap[COORD_W-1:0]
                                                                      : w_ssum[COORD_W-1:0];
    end

    assign w_plat_any  = |w_hit;
    assign w_ball_on   = in_box(DrawX, BallX, Ball_size)   && in_box(DrawY, BallY, Ball_size);
    assign w_cannon_on = in_box(DrawX, CannonX, CannonS)   && in_box(DrawY, CannonY, CannonS);

    // Stage 1: object hits. Stage 2: colour by priority. Output stays 0 until
    // stage 1 holds a real pixel after reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_vld    <= 1'b0;
            r_plat_hit  <= 1'b0;
            r_ball_on   <= 1'b0;
            r_cannon_on <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_s1_vld    <= 1'b1;
            r_plat_hit  <= w_plat_any;
            r_ball_on   <= w_ball_on;
            r_cannon_on <= w_cannon_on;
            if (!r_s1_vld)        r_rgb <= '0;
            else if (r_ball_on)   r_rgb <= BALL_RGB;
            else if (r_plat_hit)  r_rgb <= PLAT_RGB;
            else if (r_cannon_on) r_rgb <= CANNON_RGB;
            else                  r_rgb <= BG_RGB;
        end
    end

    assign Red   = r_rgb[23:16];
    assign Green = r_rgb[15:8];
    assign Blue  = r_rgb[7:0];

`ifdef PLAT_COLLIDE_EN
    logic w_coll, r_sticky, r_hit_frame;
    assign w_coll = w_ball_on && w_plat_any;

    // A collision on the commit cycle itself still counts for the closing frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sticky    <= 1'b0;
            r_hit_frame <= 1'b0;
        end else if (frame_start) begin
            r_hit_frame <= r_sticky | w_coll;
            r_sticky    <= 1'b0;
        end else if (w_coll) begin
            r_sticky    <= 1'b1;
        end
    end
    assign hit_frame = r_hit_frame;
`else
    assign hit_frame = 1'b0;
`endif
endmodule

// File: tb/tb_platform_renderer.sv
module tb_platform_renderer;
    localparam int NP = 12;
    localparam int CW = 10;
    localparam logic [23:0] BG = 24'h696969, PL = 24'h66BB11, BA = 24'hCAC92E, CA = 24'hFF0000;

    logic          Clk = 1'b0, Reset_n = 1'b0;
    logic          wr_en = 0, wr_valid = 0, frame_start = 0;
    logic [3:0]    wr_idx = '0;
    logic [CW-1:0] wr_x = '0, wr_y = '0, scroll_dy = '0, DrawX = '0, DrawY = '0;
    logic [CW-1:0] BallX = 10'd900, BallY = 10'd900, Ball_size = '0;
    logic [CW-1:0] CannonX = 10'd1000, CannonY = 10'd1000, CannonS = '0;
    logic [7:0]    Red, Green, Blue;
    logic          hit_frame;

    platform_renderer #(.NUM_PLAT(NP), .COORD_W(CW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_valid(wr_valid), .frame_start(frame_start), .scroll_dy(scroll_dy),
        .DrawX(DrawX), .DrawY(DrawY), .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size),
        .CannonX(CannonX), .CannonY(CannonY), .CannonS(CannonS),
        .Red(Red), .Green(Green), .Blue(Blue), .hit_frame(hit_frame)
    );

    always #5 Clk = ~Clk;

    typedef struct { bit v; logic [23:0] rgb; string tag; } sb_t;
    sb_t sbq[$];
    int  n_chk = 0, n_pass = 0;

`ifdef PLAT_COLLIDE_EN
    localparam logic EXP_HIT = 1'b1;
`else
    localparam logic EXP_HIT = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock; the entry pushed this cycle is compared two edges later.
    task automatic tick(input bit v = 0, input logic [23:0] e = '0, input string tag = "");
        sb_t s;
        s.v = v; s.rgb = e; s.tag = tag;
        sbq.push_back(s);
        @(posedge Clk); #1;
        while (sbq.size() > 1) begin
            s = sbq.pop_front();
            if (s.v) check(s.tag, {8'h0, Red, Green, Blue}, {8'h0, s.rgb});
        end
        wr_en = 0; frame_start = 0; scroll_dy = '0;
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] e, input string tag);
        DrawX = CW'(x); DrawY = CW'(y);
        tick(1, e, tag);
    endtask

    task automatic wr(input int idx, input bit v, input int x, input int y);
        wr_en = 1; wr_idx = 4'(idx); wr_valid = v; wr_x = CW'(x); wr_y = CW'(y);
    endtask

    task automatic commit(input int dy);
        frame_start = 1; scroll_dy = CW'(dy);
        tick();
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        check("rst_hit", {31'h0, hit_frame}, 32'h0);
        Reset_n = 1;
        tick();
        check("rst_lat", {8'h0, Red, Green, Blue}, 32'h0);

        // 1: empty table sweep
        for (int k = 0; k < 24; k++)
            pix($urandom_range(0, 799), $urandom_range(0, 479), BG, "sweep_bg");
        check("sweep_hit", {31'h0, hit_frame}, 32'h0);

        // 2: shadow write invisible until commit
        wr(3, 1, 100, 200);
        pix(100, 200, BG, "pre_commit");
        pix(100, 200, BG, "no_commit");
        commit(0);
        pix(100, 200, PL, "plat_ctr");
        pix(84, 196, PL, "plat_tl");
        pix(116, 204, PL, "plat_br");
        pix(117, 200, BG, "plat_x_out");
        pix(100, 205, BG, "plat_y_out");

        // 3: priority
        BallX = 100; BallY = 200; Ball_size = 4;
        CannonX = 100; CannonY = 200; CannonS = 4;
        pix(100, 200, BA, "prio_ball");
        BallX = 500; BallY = 400;
        pix(100, 200, PL, "prio_plat");
        wr(3, 0, 100, 200);
        commit(0);
        check("hit_set", {31'h0, hit_frame}, {31'h0, EXP_HIT});
        pix(100, 200, CA, "prio_cannon");
        CannonX = 1000; CannonY = 1000; CannonS = 0;
        pix(100, 200, BG, "prio_bg");

        // 4: scroll with wrap
        wr(0, 1, 50, 470);
        commit(20);
        check("hit_clr", {31'h0, hit_frame}, 32'h0);
        pix(50, 10, PL, "scr_ctr");
        pix(50, 6, PL, "scr_top");
        pix(50, 14, PL, "scr_bot");
        pix(50, 15, BG, "scr_below");
        pix(50, 5, BG, "scr_above");
        pix(50, 470, BG, "scr_old_y");
        pix(66, 10, PL, "scr_xedge");
        pix(67, 10, BG, "scr_xout");
        commit(470);
        pix(50, 0, PL, "wrap_row0");
        pix(50, 4, PL, "wrap_row4");
        pix(50, 5, BG, "wrap_row5");
        pix(50, 479, BG, "wrap_nosplit");

        // 5: same-cycle write+commit, scroll back to exactly 0
        pix(300, 300, BG, "s5_pre");
        wr(5, 1, 300, 300);
        commit(470);
        pix(300, 300, PL, "same_cycle_wr");
        pix(50, 470, PL, "scroll_eq_h");
        wr(13, 1, 600, 100);
        tick();
        wr(1, 1, 5, 2);
        commit(0);
        pix(600, 100, BG, "idx_oob");
        pix(0, 0, PL, "near0");
        pix(21, 0, PL, "near0_edge");
        pix(22, 0, BG, "near0_out");
        pix(1020, 0, BG, "near0_nowrap");

        // reset mid-line
        DrawX = 300; DrawY = 300;
        tick(); tick();
        Reset_n = 0;
        #1;
        check("rst_mid_rgb", {8'h0, Red, Green, Blue}, 32'h0);
        check("rst_mid_hit", {31'h0, hit_frame}, 32'h0);
        sbq.delete();
        @(posedge Clk); #1;
        Reset_n = 1;
        tick();
        check("rst_mid_lat", {8'h0, Red, Green, Blue}, 32'h0);
        commit(0);
        pix(300, 300, BG, "cleared_5");
        pix(50, 470, BG, "cleared_0");
        pix(0, 0, BG, "cleared_1");
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
